wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Hardware Wishbone classic single-cycle master that converts a valid/ready command stream into bus read/write cycles towards the SPI core's Wishbone slave port.
- Returns read data and error status on a valid/ready response stream; forwards the core interrupt as a registered flag.
- Sits directly upstream of the SPI core register interface and replaces the bench-driven bus master in system-level builds.

Parameters:
- AW, 5, Wishbone address width
- DW, 32, Wishbone data width; byte-select width is DW/8
- TIMEOUT, 64, max cycles stb may wait for ack/err before abort (used only with the optional feature); must be >= 2

Ports:
- wb_clk_i  input  1  system clock, all logic on rising edge
- wb_rst_i  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&ready
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  AW  target register address
- cmd_dat  input  DW  write data (ignored for reads)
- cmd_sel  input  DW/8  byte selects
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&ready
- rsp_dat  output  DW  read data (0 for writes)
- rsp_err  output  1  cycle terminated by wb_err_i or timeout
- wb_adr_o  output  AW  bus address
- wb_dat_o  output  DW  bus write data
- wb_sel_o  output  DW/8  bus byte selects
- wb_we_o  output  1  bus write enable
- wb_stb_o  output  1  bus strobe
- wb_cyc_o  output  1  bus cycle
- wb_dat_i  input  DW  bus read data
- wb_ack_i  input  1  slave acknowledge
- wb_err_i  input  1  slave error
- wb_int_i  input  1  slave interrupt
- irq_o  output  1  wb_int_i registered once

Behaviour:
- Reset (async assert, sync-free release): state IDLE; cmd_ready=1 after reset; rsp_valid, rsp_err, wb_stb_o, wb_cyc_o, wb_we_o, irq_o = 0; rsp_dat, wb_adr_o, wb_dat_o, wb_sel_o = 0.
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid: register adr/dat/sel/we onto bus outputs, assert stb and cyc from next cycle, go BUS.
- BUS: cmd_ready=0; stb/cyc held high, bus outputs stable. On rising edge with wb_ack_i or wb_err_i high: stb/cyc drop next cycle, rsp_valid=1 next cycle, go RESP. ack -> rsp_err=0, rsp_dat=wb_dat_i on reads, 0 on writes. err -> rsp_err=1, rsp_dat=0. ack and err together: err wins.
- Minimum latency: command accept edge N, stb high N+1, zero-wait ack sampled at N+2, rsp_valid at N+2 to N+3 boundary (visible after edge N+2). One outstanding transaction only.
- RESP: rsp_valid, rsp_dat, rsp_err held stable until rsp_valid&rsp_ready; then rsp_valid=0 and state IDLE next cycle. cmd_ready stays 0 in RESP (no overlap).
- wb_ack_i/wb_err_i outside BUS: ignored.
- Reset mid-cycle: stb/cyc drop immediately (async), pending command and response lost.
- irq_o = wb_int_i delayed one cycle, independent of FSM.

Optional Feature:
- Macro WB_CMD_MASTER_TIMEOUT_EN.
- Defined: a counter clears on BUS entry and increments each BUS cycle without ack/err. When it reaches TIMEOUT-1 with no ack/err, the cycle aborts exactly as an error: stb/cyc drop, rsp_err=1, rsp_dat=0. An ack on the terminal cycle wins over timeout.
- Undefined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- Write adr=0x04, dat=0xDEADBEEF, sel=0xF, slave acks 1 cycle after stb -> wb_we_o=1 with stable bus values during stb; rsp_valid with rsp_err=0, rsp_dat=0.
- Read adr=0x10, slave returns 0x12345678 after 3 wait cycles -> stb held 4 cycles; rsp_dat=0x12345678, rsp_err=0.
- Read where slave asserts ack and err on the same edge -> rsp_err=1, rsp_dat=0; next command accepted only after rsp handshake.
- rsp_ready held low 5 cycles, cmd_valid held high -> cmd_ready stays 0, rsp fields stable; second command starts the cycle after rsp handshake.
- Assert wb_rst_i while stb high -> stb/cyc/rsp_valid 0 immediately; after release cmd_ready=1.
- With WB_CMD_MASTER_TIMEOUT_EN and TIMEOUT=8, slave never responds -> stb high exactly 8 cycles, then rsp_err=1. Without the macro, stb stays high for 100+ cycles.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-cycle bus master.
// Converts a valid/ready command stream into Wishbone read/write cycles and
// returns read data and error status on a valid/ready response stream.
// The slave interrupt is forwarded as a registered flag (irq_o).
// One transaction is outstanding at a time: IDLE -> BUS -> RESP -> IDLE.
// Bus outputs are registered on the accept edge and the strobe rises one
// cycle later, so the address/data are already settled when stb goes high.
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a bus cycle with
// an error after TIMEOUT strobe cycles without ack/err.

module wb_cmd_master #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // command stream
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    // response stream
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    // Wishbone master port
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_stb_o,
    output logic            wb_cyc_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_int_i,
    output logic            irq_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // A timeout shorter than two cycles cannot be expressed by the counter.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("wb_cmd_master: TIMEOUT must be >= 2");
    end

    // High on the strobe cycle where the slave has run out of time.
    logic to_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] to_cnt;
    assign to_hit = (to_cnt == CW'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Transaction FSM with all stream and bus outputs registered.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values present before the clock edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_adr;
                        wb_dat_o  <= cmd_dat;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end

                BUS: begin
                    if (!wb_stb_o) begin
                        // Setup cycle: bus values are stable, raise the strobe.
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                    end else if (wb_err_i || (to_hit && !wb_ack_i)) begin
                        // Error wins over ack; timeout aborts like an error.
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= '0;
                        state     <= RESP;
                    end else if (wb_ack_i) begin
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
                        state     <= RESP;
                    end else begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    wb_cyc_o  <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt flag: slave interrupt delayed by one clock, FSM-independent.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= wb_int_i;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: self-checking bench for wb_cmd_master.
// Directed vector table plus randomized transactions checked against a
// behavioural response model; hand-written sequences cover reset during a
// bus cycle, interrupt forwarding, stray ack/err and the no-response case.

module tb_wb_cmd_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic [DW/8-1:0] cmd_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;
    logic            rsp_err;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_stb_o;
    logic            wb_cyc_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_int_i;
    logic            irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_int_i (wb_int_i),
        .irq_o    (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave response kinds used by the vectors.
    localparam logic [1:0] K_ACK  = 2'd0;
    localparam logic [1:0] K_ERR  = 2'd1;
    localparam logic [1:0] K_BOTH = 2'd2;

    typedef struct {
        logic            we;
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
        logic [DW/8-1:0] sel;
        int              wt;     // wait cycles before the slave answers
        logic [1:0]      kind;
        logic [DW-1:0]   rdata;
        int              rdly;   // cycles rsp_ready is held low
        bit              hold;   // keep cmd_valid high through the response
        logic [DW-1:0]   exp_dat;
        logic            exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: any error (alone or with ack) gives err=1/data=0;
    // a clean ack returns slave data on reads and zero on writes.
    function automatic logic [32:0] model_rsp(input logic we, input logic [1:0] kind,
                                              input logic [31:0] rdata);
        if (kind != K_ACK) return {1'b1, 32'h0};
        return {1'b0, (we ? 32'h0 : rdata)};
    endfunction

    // One complete transaction; called and returns on a falling edge.
    task automatic do_txn(input vec_t v);
        int unsigned i;
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        wb_dat_i  = v.rdata;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(negedge wb_clk_i);
        if (!v.hold) cmd_valid = 1'b0;
        check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        check("stb_setup", {31'd0, wb_stb_o}, 32'd0);
        check("adr_setup", {27'd0, wb_adr_o}, {27'd0, v.adr});
        for (i = 0; i <= v.wt; i++) begin
            @(negedge wb_clk_i);
            check("stb_high", {31'd0, wb_stb_o}, 32'd1);
            check("cyc_high", {31'd0, wb_cyc_o}, 32'd1);
            check("bus_adr", {27'd0, wb_adr_o}, {27'd0, v.adr});
            check("bus_dat", wb_dat_o, v.dat);
            check("bus_sel", {28'd0, wb_sel_o}, {28'd0, v.sel});
            check("bus_we", {31'd0, wb_we_o}, {31'd0, v.we});
            check("rsp_valid_busy", {31'd0, rsp_valid}, 32'd0);
            if (i == v.wt) begin
                wb_ack_i = (v.kind == K_ACK) || (v.kind == K_BOTH);
                wb_err_i = (v.kind == K_ERR) || (v.kind == K_BOTH);
            end
        end
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hBAD0_BAD0;
        check("stb_drop", {31'd0, wb_stb_o}, 32'd0);
        check("cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_dat", rsp_dat, v.exp_dat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        for (int k = 0; k < v.rdly; k++) begin
            @(negedge wb_clk_i);
            check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("rsp_hold_dat", rsp_dat, v.exp_dat);
            check("rsp_hold_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
            check("rsp_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        if (!v.hold) cmd_valid = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int unsigned stb_cnt;
        logic        prev_int;
        vec_t        v;
        logic [32:0] m;
        int unsigned r;

        vecs[0] = '{1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 1, K_ACK,  32'h0,        0, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 5'h10, 32'h0,        4'hF, 3, K_ACK,  32'h12345678, 0, 1'b0, 32'h12345678, 1'b0};
        vecs[2] = '{1'b0, 5'h08, 32'h0,        4'hF, 0, K_BOTH, 32'hAAAA5555, 2, 1'b1, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 5'h0C, 32'h0,        4'h3, 0, K_ACK,  32'hCAFEF00D, 5, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1'b1, 5'h1F, 32'h01020304, 4'h3, 2, K_ERR,  32'h55555555, 1, 1'b0, 32'h0,        1'b1};
        vecs[5] = '{1'b0, 5'h00, 32'h0,        4'h1, 0, K_ACK,  32'hFFFFFFFF, 0, 1'b0, 32'hFFFFFFFF, 1'b0};

        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_int_i  = 1'b0;

        // Reset state
        #3;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_stb_cyc", {30'd0, wb_stb_o, wb_cyc_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_bus", {wb_adr_o, wb_sel_o, 23'd0}, 32'd0);
        check("rst_dat_o", wb_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Interrupt forwarding: one-cycle delayed copy
        prev_int = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wb_int_i = 1'($urandom_range(0, 1));
            @(negedge wb_clk_i);
            check("irq_delay", {31'd0, irq_o}, {31'd0, wb_int_i});
            prev_int = wb_int_i;
        end
        wb_int_i = 1'b0;

        // Stray ack/err in IDLE must be ignored
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("idle_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("idle_ack_stb", {31'd0, wb_stb_o}, 32'd0);
        check("idle_ack_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed vector table
        for (int k = 0; k < 6; k++) do_txn(vecs[k]);

        // Randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.adr   = AW'($urandom_range(0, 31));
            v.dat   = $urandom;
            v.sel   = 4'($urandom_range(0, 15));
            v.wt    = int'($urandom_range(0, 4));
            r       = $urandom_range(0, 5);
            v.kind  = (r < 4) ? K_ACK : ((r == 4) ? K_ERR : K_BOTH);
            v.rdata = $urandom;
            v.rdly  = int'($urandom_range(0, 3));
            v.hold  = 1'b0;
            m       = model_rsp(v.we, v.kind, v.rdata);
            v.exp_err = m[32];
            v.exp_dat = m[31:0];
            do_txn(v);
        end

        // Reset while strobe is high
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 5'h07;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        @(negedge wb_clk_i);
        check("pre_rst_stb", {31'd0, wb_stb_o}, 32'd1);
        #1 wb_rst_i = 1'b1;
        #1;
        check("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_stb", {31'd0, wb_stb_o}, 32'd0);

        // Slave never responds
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 5'h03;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        stb_cnt   = 0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        for (int k = 0; k < 200; k++) begin
            @(negedge wb_clk_i);
            if (wb_stb_o) stb_cnt++;
            else if (stb_cnt > 0) break;
        end
        check("timeout_stb_cycles", stb_cnt, TO);
        check("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("timeout_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("timeout_rsp_dat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        check("timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`else
        repeat (120) begin
            @(negedge wb_clk_i);
            if (wb_stb_o) stb_cnt++;
        end
        check("no_timeout_stb_cycles", stb_cnt, 32'd120);
        check("no_timeout_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("recover_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
